// File: rtl/cache_ctrl_pkg.sv
// Shared types and sizing for the 8-way cache way controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_ctrl_pkg;

    localparam int WAYS   = 8;
    localparam int WAY_W  = 3;
    localparam int PLRU_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_RESP   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/plru8.sv
// Tree-PLRU for 8 ways: next word after an access, and the current victim.
// Latency: purely combinational.
// Backpressure: none.
module plru8
    import cache_ctrl_pkg::*;
(
    input  logic [PLRU_W-1:0] plru,
    input  logic [WAY_W-1:0]  way,
    output logic [PLRU_W-1:0] plru_next,
    output logic [WAY_W-1:0]  victim
);

    logic [2:0] upd_l2, upd_l3, vic_l2, vic_l3;
    logic       vic_mid;

    // Every node on the accessed path is pointed at the other subtree.
    always_comb begin
        upd_l2            = 3'd1 + {2'b00, way[2]};
        upd_l3            = 3'd3 + {1'b0, way[2:1]};
        plru_next         = plru;
        plru_next[0]      = ~way[2];
        plru_next[upd_l2] = ~way[1];
        plru_next[upd_l3] = ~way[0];
    end

    always_comb begin
        vic_l2  = 3'd1 + {2'b00, plru[0]};
        vic_mid = plru[vic_l2];
        vic_l3  = 3'd3 + {1'b0, plru[0], vic_mid};
        victim  = {plru[0], vic_mid, plru[vic_l3]};
    end

endmodule

// File: rtl/cache_way_ctrl.sv
// 8-way set-associative tag/valid/PLRU controller with refill handshake.
// Latency: hit response 2 cycles after accept; miss waits on fill_done, then 1 cycle.
// Backpressure: one request in flight; req_ready low until the response is taken.
module cache_way_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int TAG_W = 20,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             fill_req,
    output logic [WAY_W-1:0] fill_way,
    input  logic             fill_done,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [WAY_W-1:0] way_sel
);

    state_t             state;
    logic               live_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   victim_q;
    logic [WAY_W-1:0]   way_sel_q;
    logic               hit_q;

    logic [WAYS-1:0]    valid_mem [SETS];
    logic [PLRU_W-1:0]  plru_mem  [SETS];
    logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];

    logic               any_hit;
    logic [WAY_W-1:0]   hit_way;
    logic               has_inv;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   acc_way;
    logic [WAY_W-1:0]   plru_victim;
    logic [PLRU_W-1:0]  plru_upd;
    logic [WAY_W-1:0]   miss_victim;

    always_comb begin
        any_hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[idx_q][w] && (tag_mem[idx_q][w] == tag_q)) begin
                any_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[idx_q][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign acc_way     = (state == ST_FILL) ? victim_q : hit_way;
    assign miss_victim = has_inv ? inv_way : plru_victim;

    plru8 u_plru (
        .plru      (plru_mem[idx_q]),
        .way       (acc_way),
        .plru_next (plru_upd),
        .victim    (plru_victim)
    );

    // live_q keeps req_ready low while reset is held and for no longer.
    assign req_ready  = live_q && (state == ST_IDLE) && !flush;
    assign fill_req   = (state == ST_FILL);
    assign fill_way   = victim_q;
    assign resp_valid = (state == ST_RESP);
    assign resp_hit   = hit_q;
    assign way_sel    = way_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            live_q    <= 1'b0;
            idx_q     <= '0;
            tag_q     <= '0;
            victim_q  <= '0;
            way_sel_q <= '0;
            hit_q     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else begin
            live_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end else if (req_valid && req_ready) begin
                        idx_q <= req_index;
                        tag_q <= req_tag;
                        state <= ST_LOOKUP;
                    end
                end
                ST_FLUSH: begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_mem[s] <= '0;
                    end
                    state <= ST_IDLE;
                end
                ST_LOOKUP: begin
                    if (any_hit) begin
                        way_sel_q       <= hit_way;
                        hit_q           <= 1'b1;
                        plru_mem[idx_q] <= plru_upd;
                        state           <= ST_RESP;
                    end else begin
                        victim_q <= miss_victim;
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        valid_mem[idx_q][victim_q] <= 1'b1;
                        plru_mem[idx_q]            <= plru_upd;
                        way_sel_q                  <= victim_q;
                        hit_q                      <= 1'b0;
                        state                      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if ((state == ST_FILL) && fill_done) begin
            tag_mem[idx_q][victim_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: directed vector table, corner sequences, random traffic vs. a reference model.
module tb_cache_way_ctrl;

    localparam int SETS  = 16;
    localparam int TAG_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_index = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic             fill_req;
    logic [2:0]       fill_way;
    logic             fill_done = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_hit;
    logic [2:0]       way_sel;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cache_way_ctrl #(.SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .flush      (flush),
        .fill_req   (fill_req),
        .fill_way   (fill_way),
        .fill_done  (fill_done),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .way_sel    (way_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: per set, per way valid/tag, and the PLRU tree as one
    // direction flag per node, addressed by (level, path prefix).
    bit               mvalid [SETS][8];
    logic [TAG_W-1:0] mtag   [SETS][8];
    bit               mdir   [SETS][3][4];

    function automatic int m_victim(input int s);
        int p = 0;
        for (int lvl = 0; lvl < 3; lvl++) p = p * 2 + int'(mdir[s][lvl][p]);
        return p;
    endfunction

    task automatic m_touch(input int s, input int w);
        for (int lvl = 0; lvl < 3; lvl++)
            mdir[s][lvl][w >> (3 - lvl)] = !(((w >> (2 - lvl)) & 1) == 1);
    endtask

    task automatic m_lookup(input int s, input logic [TAG_W-1:0] t, output bit hit, output int way);
        hit = 0;
        way = -1;
        for (int w = 0; w < 8; w++)
            if (mvalid[s][w] && mtag[s][w] == t) begin hit = 1; way = w; end
        if (!hit) begin
            for (int w = 7; w >= 0; w--) if (!mvalid[s][w]) way = w;
            if (way < 0) way = m_victim(s);
        end
    endtask

    task automatic m_clear_valid();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < 8; w++) mvalid[s][w] = 0;
    endtask

    task automatic m_reset();
        m_clear_valid();
        for (int s = 0; s < SETS; s++)
            for (int l = 0; l < 3; l++) for (int p = 0; p < 4; p++) mdir[s][l][p] = 0;
    endtask

    // One request through handshake, optional fill, and response (with stall).
    task automatic txn(input int s, input logic [TAG_W-1:0] t, input int stall, input int fdel,
                       output bit got_hit, output int got_way, output bit fill_seen,
                       output int fway, output int lat, output bit timed_out);
        int  guard;
        int  fcnt;
        bit  fstable;
        bit  rstable;
        got_hit = 0; got_way = 0; fill_seen = 0; fway = 0; lat = 0; timed_out = 0;
        fcnt = 0; fstable = 1; rstable = 1;
        @(negedge clk);
        req_index = 4'(s);
        req_tag   = t;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            timed_out = 1;
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            while (lat < 60) begin
                @(negedge clk);
                lat++;
                fill_done = 1'b0;
                if (resp_valid) break;
                if (fill_req) begin
                    if (!fill_seen) fway = int'(fill_way);
                    else if (int'(fill_way) != fway) fstable = 0;
                    fill_seen = 1;
                    if (fcnt == fdel) fill_done = 1'b1;
                    fcnt++;
                end
            end
            fill_done = 1'b0;
            if (!resp_valid) begin
                timed_out = 1;
            end else begin
                got_hit = resp_hit;
                got_way = int'(way_sel);
                if (fill_seen) chk("fill_way_stable", 32'(fstable), 1);
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    if (!(resp_valid && resp_hit == got_hit && int'(way_sel) == got_way && !req_ready))
                        rstable = 0;
                end
                if (stall > 0) chk("resp_hold_stable", 32'(rstable), 1);
                resp_ready = 1'b1;
                @(posedge clk);
                #1 resp_ready = 1'b0;
            end
        end
    endtask

    // Model-checked transaction; optional table expectations checked as well.
    task automatic run(input int s, input logic [TAG_W-1:0] t, input int stall, input int fdel,
                       input bit known, input bit ehit, input int eway);
        bit mhit, ghit, fseen, tmo;
        int mway, gway, fway, lat;
        m_lookup(s, t, mhit, mway);
        txn(s, t, stall, fdel, ghit, gway, fseen, fway, lat, tmo);
        chk("timeout", 32'(tmo), 0);
        chk("resp_hit", 32'(ghit), 32'(mhit));
        chk("way_sel", 32'(gway), 32'(mway));
        if (mhit) begin
            chk("hit_latency", 32'(lat), 2);
            chk("hit_no_fill", 32'(fseen), 0);
        end else begin
            chk("miss_fill_seen", 32'(fseen), 1);
            chk("fill_way", 32'(fway), 32'(mway));
            chk("miss_latency", 32'(lat), 32'(fdel + 3));
        end
        if (known) begin
            chk("table_hit", 32'(ghit), 32'(ehit));
            chk("table_way", 32'(gway), 32'(eway));
        end
        if (!mhit) begin
            mvalid[s][mway] = 1;
            mtag[s][mway]   = t;
        end
        m_touch(s, mway);
    endtask

    typedef struct {
        int               idx;
        logic [TAG_W-1:0] tag;
        bit               hit;
        int               way;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        tbl[0]  = '{3, 20'h12345, 1'b0, 0};
        tbl[1]  = '{3, 20'h12345, 1'b1, 0};
        for (int k = 0; k < 8; k++) tbl[2 + k] = '{5, 20'hA0000 + 20'(k), 1'b0, k};
        tbl[10] = '{5, 20'hA0008, 1'b0, 0};
        tbl[11] = '{5, 20'hA0003, 1'b1, 3};

        m_reset();
        #12;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_fill_req", 32'(fill_req), 0);
        chk("rst_fill_way", 32'(fill_way), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_hit", 32'(resp_hit), 0);
        chk("rst_way_sel", 32'(way_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(req_ready), 1);

        for (int i = 0; i < 12; i++)
            run(tbl[i].idx, tbl[i].tag, i % 3, i % 2, 1'b1, tbl[i].hit, tbl[i].way);

        // Response held off for 5 cycles on a hit.
        run(3, 20'h12345, 5, 0, 1'b1, 1'b1, 0);

        // Flush wins over a simultaneous request.
        @(negedge clk);
        req_index = 4'd3; req_tag = 20'h12345; req_valid = 1'b1; flush = 1'b1;
        #1 chk("flush_blocks_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1 begin flush = 1'b0; req_valid = 1'b0; end
        @(negedge clk);
        chk("ready_low_in_flush", 32'(req_ready), 0);
        m_clear_valid();
        run(3, 20'h12345, 0, 1, 1'b1, 1'b0, 0);

        // Reset asserted in the middle of a fill.
        @(negedge clk);
        req_index = 4'd7; req_tag = 20'h77777; req_valid = 1'b1;
        seen = 0;
        while (!req_ready && seen < 20) begin @(negedge clk); seen++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !fill_req; i++) @(negedge clk);
        chk("fill_before_reset", 32'(fill_req), 1);
        #2 rst_n = 1'b0;
        #1 begin
            chk("fill_req_on_reset", 32'(fill_req), 0);
            chk("resp_valid_on_reset", 32'(resp_valid), 0);
            chk("req_ready_on_reset", 32'(req_ready), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1 chk("ready_after_midfill_reset", 32'(req_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("no_resp_after_reset", 32'(seen), 0);
        run(7, 20'h77777, 0, 0, 1'b1, 1'b0, 0);
        run(3, 20'h12345, 0, 0, 1'b1, 1'b0, 0);

        // Random traffic over a few sets and a small tag pool.
        for (int n = 0; n < 150; n++) begin
            int r, s;
            int sets_pick [4];
            sets_pick = '{0, 1, 2, 15};
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                @(negedge clk);
                flush = 1'b1;
                req_valid = 1'($urandom_range(0, 1));
                #1 chk("rand_flush_ready", 32'(req_ready), 0);
                @(posedge clk);
                #1 begin flush = 1'b0; req_valid = 1'b0; end
                m_clear_valid();
            end else if (r == 1) begin
                @(negedge clk);
                fill_done = 1'b1;
                @(posedge clk);
                #1 fill_done = 1'b0;
            end
            s = sets_pick[$urandom_range(0, 3)];
            run(s, 20'h30000 + 20'($urandom_range(0, 11)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_way_ctrl.md
CACHE_WAY_CTRL -- requirements
Module: cache_way_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 16, meaning the number of cache sets (power of two, 2..256).
REQ-002 SHALL have parameter TAG_W, default 20, meaning the tag width in bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning a lookup request is present.
REQ-006 SHALL have port req_ready, output, 1, meaning the controller accepts a request this cycle.
REQ-007 SHALL have port req_index, input, log2(SETS), meaning the set index.
REQ-008 SHALL have port req_tag, input, TAG_W, meaning the lookup tag.
REQ-009 SHALL have port flush, input, 1, meaning invalidate all lines.
REQ-010 SHALL have port fill_req, output, 1, meaning a line refill is requested from memory.
REQ-011 SHALL have port fill_way, output, 3, meaning the victim way being refilled.
REQ-012 SHALL have port fill_done, input, 1, meaning the refill data has been written.
REQ-013 SHALL have port resp_valid, output, 1, meaning a response is present.
REQ-014 SHALL have port resp_ready, input, 1, meaning the consumer takes the response.
REQ-015 SHALL have port resp_hit, output, 1, meaning 1 for hit and 0 for miss-then-fill.
REQ-016 SHALL have port way_sel, output, 3, meaning the select driving the 8-way 256-bit line multiplexer.

Function
REQ-017 SHALL hold per set: 8 valid bits, 8 tags of TAG_W bits, and a 7-bit tree-PLRU word.
REQ-018 SHALL implement FSM states IDLE, LOOKUP, FILL, RESP, FLUSH.
REQ-019 SHALL drive req_ready=1 only in IDLE with flush=0; a handshake occurs when req_valid&&req_ready, and index/tag are latched then -> LOOKUP.
REQ-020 SHALL, in IDLE with flush=1, enter FLUSH regardless of req_valid (flush wins), clear all valid bits in that one cycle, and return to IDLE; PLRU words are left unchanged.
REQ-021 SHALL, in LOOKUP, compare the latched tag against all valid ways of the latched set; a match is a hit (at most one match, by construction).
REQ-022 SHALL, on a hit, set way_sel to the hit way, update PLRU, and enter RESP; the handshake occurs at cycle N, resp_valid=1 at N+2.
REQ-023 SHALL, on a miss, select the victim as the lowest-index invalid way, else the PLRU victim, then enter FILL.
REQ-024 SHALL, in FILL, assert fill_req=1 with fill_way=victim, both stable until fill_done; fill_done outside FILL SHALL be ignored.
REQ-025 SHALL, on fill_done in FILL, write the tag, set valid, update PLRU for the victim, set way_sel=victim and resp_hit=0, and enter RESP on the next cycle.
REQ-026 SHALL, in RESP, hold resp_valid, resp_hit and way_sel stable until resp_ready=1; on that cycle it returns to IDLE.
REQ-027 SHALL encode PLRU as follows: bit0 is the root, bits1-2 are level 2, and bits3-6 are level 3; bit=0 means the victim lies in the lower half. On access, each bit on the path points away from the accessed way; the victim is found by following the bits (all-zero gives way 0).
REQ-028 SHALL ignore flush outside IDLE; flush is not queued.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state IDLE, all valid bits 0, all PLRU words 0, and req_ready=0, fill_req=0, fill_way=0, resp_valid=0, resp_hit=0, way_sel=0; tags are don't-care.
REQ-030 SHALL abandon any lookup or fill in progress when reset asserts mid-operation, with no response issued; req_ready=1 on the first edge after release.

Structure
REQ-031 SHALL place the state enum and the constants WAYS=8, WAY_W=3, PLRU_W=7 in the shared package cache_ctrl_pkg.
REQ-032 SHALL implement PLRU update and victim selection in the combinational sub-module plru8 (inputs: plru word, access way; outputs: next word, victim).

Verification
REQ-033 SHALL cover: after reset, req index=3 tag=0x12345 -> fill_req with fill_way=0; fill_done -> resp_valid, resp_hit=0, way_sel=0.
REQ-034 SHALL cover: repeat REQ-033's request -> resp_valid exactly 2 cycles after the handshake, resp_hit=1, way_sel=0, fill_req never asserted.
REQ-035 SHALL cover: 8 distinct-tag misses on set 5 -> fill_way 0..7 in order; a 9th miss -> fill_way=0 (PLRU victim).
REQ-036 SHALL cover: flush and req_valid both asserted in IDLE -> req_ready=0, FLUSH taken; a prior hit tag then misses.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid, resp_hit, way_sel stable throughout; req_ready=0.
REQ-038 SHALL cover: rst_n pulsed low during FILL -> fill_req=0 immediately, no resp_valid, set contents invalid afterwards.
